// File: rtl/hwpe_stream_package.sv
// Shared hwpe-stream types: sideband layout carried next to framed beats.
package hwpe_stream_package;

    localparam int unsigned FRAMER_SIDECH_WIDTH = 3;

    typedef struct packed {
        logic parity;
        logic last;
        logic first;
    } framer_sidech_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes; sink accepts, source produces.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport sink   (input  valid, input  data, input  strb, output ready);
    modport source (output valid, output data, output strb, input  ready);

endinterface

// File: rtl/hwpe_stream_framer_skid.sv
// Two-entry skid buffer (output reg + skid reg), 1-cycle latency, 1 beat/cycle.
// Backpressure: in_vld is an already-accepted beat; skid_full_nxt lets the owner register its ready.
module hwpe_stream_framer_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy,
    output logic             skid_full_nxt
);

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (!out_vld_q || out_rdy) begin
            // Output slot frees up: the oldest beat (skid first) moves forward.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = in_vld;
                skid_dat_d = in_dat;
            end else begin
                out_vld_d  = in_vld;
                out_dat_d  = in_dat;
            end
        end else if (in_vld) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else if (clear_i) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign out_vld       = out_vld_q;
    assign out_dat       = out_dat_q;
    assign skid_full_nxt = skid_vld_d;

endmodule

// File: rtl/hwpe_stream_framer.sv
// Frames a stream into frame_len beats tagged first/last(/parity with HWPE_STREAM_FRAMER_PARITY_EN); 1-cycle latency.
// Backpressure: push ready is registered, high only in RUN while the skid register is empty.
module hwpe_stream_framer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           start_i,
    input  logic [CNT_WIDTH-1:0]           frame_len_i,
    output logic                           busy_o,
    output logic                           done_o,
    hwpe_stream_intf_stream.sink           push_i,
    hwpe_stream_intf_stream.source         pop_o,
    output logic [FRAMER_SIDECH_WIDTH-1:0] sidech_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
`ifdef HWPE_STREAM_FRAMER_PARITY_EN
    localparam int unsigned SIDE_BITS  = 3;
`else
    localparam int unsigned SIDE_BITS  = 2;
`endif
    localparam int unsigned PAY_WIDTH  = DATA_WIDTH + STRB_WIDTH + SIDE_BITS;
    localparam int unsigned FIRST_BIT  = DATA_WIDTH + STRB_WIDTH;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] len_q, cnt_q;
    logic                 ready_q, busy_q, done_q;
    logic                 push_acc, pop_fire, beat_first, beat_last;
    logic                 out_vld, skid_full_nxt;
    logic [PAY_WIDTH-1:0] in_dat, out_dat;
    framer_sidech_t       sidech;

    assign push_acc   = push_i.valid & ready_q;
    assign pop_fire   = out_vld & pop_o.ready;
    assign beat_first = (cnt_q == '0);
    assign beat_last  = (cnt_q == len_q - CNT_WIDTH'(1));

`ifdef HWPE_STREAM_FRAMER_PARITY_EN
    assign in_dat = {^push_i.data, beat_last, beat_first, push_i.strb, push_i.data};
`else
    assign in_dat = {beat_last, beat_first, push_i.strb, push_i.data};
`endif

    hwpe_stream_framer_skid #(
        .WIDTH (PAY_WIDTH)
    ) i_skid (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .in_vld        (push_acc),
        .in_dat        (in_dat),
        .out_vld       (out_vld),
        .out_dat       (out_dat),
        .out_rdy       (pop_o.ready),
        .skid_full_nxt (skid_full_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q <= frame_len_i;
                        cnt_q <= '0;
                        if (frame_len_i != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    ready_q <= !skid_full_nxt;
                    if (push_acc) begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (beat_last) begin
                            state_q <= FLUSH;
                            ready_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // The last-tagged beat is always the final one in flight.
                    if (pop_fire && out_dat[FIRST_BIT+1]) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sidech = '0;
        if (out_vld) begin
            sidech.first  = out_dat[FIRST_BIT];
            sidech.last   = out_dat[FIRST_BIT+1];
`ifdef HWPE_STREAM_FRAMER_PARITY_EN
            sidech.parity = out_dat[FIRST_BIT+2];
`endif
        end
    end

    assign push_i.ready = ready_q;
    assign pop_o.valid  = out_vld;
    assign pop_o.data   = out_vld ? out_dat[DATA_WIDTH-1:0] : '0;
    assign pop_o.strb   = out_vld ? out_dat[FIRST_BIT-1:DATA_WIDTH] : '0;
    assign sidech_o     = sidech;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
